pe_result_tx: RTL and testbench

- Output-side companion to the PE input wrapper: the wrapper launches a 128-bit word into the PE with a one-cycle valid pulse; this block retires the PE's result.
- Tracks every accepted launch through the PE's fixed pipeline latency and samples the PE output at exactly the right cycle.
- Buffers results in a credit-protected FIFO and drives them downstream on an AXI-Stream-style master (tvalid/tready/tdata).

---
 rtl/pe_tx_pkg.sv | 17 +
 rtl/pe_result_tx_if.sv | 42 ++++
 rtl/pe_tx_fifo.sv | 55 +++++
 rtl/pe_result_tx.sv | 112 +++++++++++
 tb/tb_pe_result_tx.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pe_tx_pkg.sv
// Shared constants, types and helpers for the PE result transmitter.
package pe_tx_pkg;

  localparam int PE_DATA_W  = 128;
  localparam int PE_LATENCY = 20;

  typedef logic [PE_DATA_W-1:0] pe_word_t;

  // Ceiling log2 for pointer/counter widths (v >= 2 expected).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pe_result_tx_if.sv
// Launch-side and AXI-Stream-side signals of the PE result transmitter.
// m_tlast exists only when PE_RESULT_TX_TLAST_EN is defined.
interface pe_result_tx_if #(
  parameter int DATA_W = pe_tx_pkg::PE_DATA_W
);
  logic              launch_valid;
  logic              launch_ready;
  logic [DATA_W-1:0] pe_data;
  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;
`ifdef PE_RESULT_TX_TLAST_EN
  logic              m_tlast;
`endif

  // Transmitter side: accepts launches, samples pe_data, drives the stream.
  modport master (
    input  launch_valid,
    input  pe_data,
    input  m_tready,
`ifdef PE_RESULT_TX_TLAST_EN
    output m_tlast,
`endif
    output launch_ready,
    output m_tvalid,
    output m_tdata
  );

  // Environment side: issues launches, provides pe_data, consumes the stream.
  modport slave (
    output launch_valid,
    output pe_data,
    output m_tready,
`ifdef PE_RESULT_TX_TLAST_EN
    input  m_tlast,
`endif
    input  launch_ready,
    input  m_tvalid,
    input  m_tdata
  );

endinterface

// File: rtl/pe_tx_fifo.sv
// Synchronous result FIFO. Pointers wrap naturally; count is one bit wider
// than the pointers so full and empty are distinguishable.
module pe_tx_fifo
  import pe_tx_pkg::*;
#(
  parameter int WIDTH = PE_DATA_W,
  parameter int DEPTH = 4,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy update; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_result_tx.sv
// PE result transmitter: tracks accepted launches through the PE's fixed
// latency, captures pe_data at the right edge into a credit-protected FIFO,
// and streams results out in launch order.
// Optional: define PE_RESULT_TX_TLAST_EN to add BURST_LEN and m_tlast.
module pe_result_tx
  import pe_tx_pkg::*;
#(
  parameter int DATA_W    = PE_DATA_W,
  parameter int LATENCY   = PE_LATENCY,
  parameter int DEPTH     = 4
`ifdef PE_RESULT_TX_TLAST_EN
  ,
  parameter int BURST_LEN = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  pe_result_tx_if.master    bus,
  output logic              busy,
  output logic              drop_err
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 2;

  logic [LATENCY-1:0] vld_pipe;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      outstanding;
  logic [AW:0]        fifo_count;
  logic [DATA_W-1:0]  head_data;
  logic               fifo_empty;
  logic               fifo_full;
  logic               accept;
  logic               capture;
  logic               pop;

  // Credits come only from registered state: no path from m_tready.
  assign outstanding      = inflight + CW'(fifo_count);
  assign bus.launch_ready = (outstanding < CW'(DEPTH));
  assign accept           = bus.launch_valid & bus.launch_ready;
  assign capture          = vld_pipe[LATENCY-1];
  assign pop              = bus.m_tvalid & bus.m_tready;

  assign bus.m_tvalid = ~fifo_empty;
  assign bus.m_tdata  = fifo_empty ? '0 : head_data;
  assign busy         = (|vld_pipe) | (fifo_count != '0);

  // Launch tracker: one bit per accepted launch, aging one stage per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Running count of ones in the launch tracker, kept alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
    end else begin
      case ({accept, capture})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky flag for a launch offered while no credit was available.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   drop_err <= 1'b0;
    else if (bus.launch_valid & ~bus.launch_ready) drop_err <= 1'b1;
  end

  pe_tx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (bus.pe_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Credits make a capture into a full FIFO unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(capture && fifo_full));

`ifdef PE_RESULT_TX_TLAST_EN
  localparam int BW = clog2(BURST_LEN) + 1;
  logic [BW-1:0] beat_cnt;

  assign bus.m_tlast = bus.m_tvalid & (beat_cnt == BW'(BURST_LEN - 1));

  // Beat counter: advances per transferred beat, wraps after the last of a burst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             beat_cnt <= '0;
    else if (pop) begin
      if (beat_cnt == BW'(BURST_LEN - 1)) beat_cnt <= '0;
      else                                 beat_cnt <= beat_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_result_tx.sv
// Randomized + directed bench for pe_result_tx against a queue-based model:
// launches are remembered by cycle number, results by value, in order.
module tb_pe_result_tx;
  import pe_tx_pkg::*;

  localparam int LAT = 20;
  localparam int DEP = 4;
  localparam int BL  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic drop_err;

  always #5 clk = ~clk;

  pe_result_tx_if #(.DATA_W(PE_DATA_W)) bus ();

  pe_result_tx #(
    .DATA_W    (PE_DATA_W),
    .LATENCY   (LAT),
    .DEPTH     (DEP)
`ifdef PE_RESULT_TX_TLAST_EN
    ,
    .BURST_LEN (BL)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .drop_err (drop_err)
  );

  // Reference model state.
  int          cyc;
  int          launches[$];
  logic [127:0] results[$];
  bit          m_drop;
  int          m_beats;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_outputs();
    int outst;
    outst = launches.size() + results.size();
    chk("m_tvalid",     bus.m_tvalid,     128'(results.size() > 0));
    chk("m_tdata",      bus.m_tdata,      (results.size() > 0) ? results[0] : 128'd0);
    chk("launch_ready", bus.launch_ready, 128'(outst < DEP));
    chk("busy",         busy,             128'(outst != 0));
    chk("drop_err",     drop_err,         128'(m_drop));
`ifdef PE_RESULT_TX_TLAST_EN
    chk("m_tlast", bus.m_tlast, 128'((results.size() > 0) && (m_beats % BL == BL - 1)));
`endif
  endtask

  // One clock cycle: check at negedge, drive inputs, advance the model to
  // the state after the following rising edge.
  task automatic step(input bit lv, input bit tr, input logic [127:0] pd);
    bit ready;
    bit pop;
    @(negedge clk);
    check_outputs();
    bus.launch_valid = lv;
    bus.m_tready     = tr;
    bus.pe_data      = pd;
    ready = (launches.size() + results.size()) < DEP;
    pop   = (results.size() > 0) && tr;
    if (pop) begin
      void'(results.pop_front());
      m_beats++;
    end
    if (launches.size() > 0) begin
      if (launches[0] + LAT == cyc) begin
        results.push_back(pd);
        void'(launches.pop_front());
      end
    end
    if (lv && ready) launches.push_back(cyc);
    else if (lv)     m_drop = 1'b1;
    cyc++;
  endtask

  task automatic model_clear();
    launches.delete();
    results.delete();
    m_drop  = 1'b0;
    m_beats = 0;
  endtask

  // Asynchronous reset mid-cycle; outputs must drop immediately.
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    bus.launch_valid = 1'b0;
    bus.m_tready     = 1'b0;
    model_clear();
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    model_clear();
    bus.launch_valid = 1'b0;
    bus.m_tready     = 1'b0;
    bus.pe_data      = '0;
    #1 reset = 1'b0;
    #1 check_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Single launch: result appears exactly LAT+1 cycles later.
    cyc = 0;
    step(1'b1, 1'b1, rnd128());
    for (int i = 1; i < 20; i++) step(1'b0, 1'b1, rnd128());
    step(1'b0, 1'b1, {16{8'hA5}});
    for (int i = 21; i < 25; i++) step(1'b0, 1'b1, rnd128());

    // Back-to-back launches, 5th dropped, drained after stall.
    cyc = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rnd128());
    for (int i = 5; i < 20; i++) step(1'b0, 1'b0, rnd128());
    for (int i = 20; i < 24; i++) step(1'b0, 1'b0, 128'(i - 19));
    for (int i = 24; i < 30; i++) step(1'b0, 1'b0, rnd128());
    for (int i = 30; i < 38; i++) step(1'b0, 1'b1, rnd128());
    do_reset();

    // Backpressure toggling over three buffered results.
    cyc = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rnd128());
    for (int i = 3; i < 25; i++) step(1'b0, 1'b0, rnd128());
    for (int i = 25; i < 37; i++) step(1'b0, bit'(i % 2), rnd128());

    // Reset with two launches in flight: nothing may emerge afterwards.
    do_reset();
    cyc = 0;
    step(1'b1, 1'b1, rnd128());
    step(1'b1, 1'b1, rnd128());
    for (int i = 2; i < 10; i++) step(1'b0, 1'b1, rnd128());
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, rnd128());

    // Launch at every credit with a ready sink (bursts for m_tlast).
    for (int i = 0; i < 80; i++) step(1'b1, 1'b1, rnd128());
    do_reset();

    // Random traffic with periodic resets.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 400; i++)
        step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, rnd128());
      do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
